// File: rtl/cache_req_arbiter_2way.sv
// ----------------------------------------------------------------------------
// cache_req_arbiter_2way
//
// Round-robin arbiter and sequencer that sits in front of cache_system_2way.
// Two requesters present read addresses over valid/ready. One request is
// serviced at a time. It is issued to the cache as a one-cycle read pulse, and
// the cache's registered result is captured one cycle later. The result is
// then returned on a single back-pressurable response channel, tagged with
// the owning requester. Saturating L1-hit / L2-hit / miss counters are
// maintained alongside.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req0_* / req1_*          request channels (valid, addr in; ready out)
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   requester owning the response
//   rsp_data                 read data
//   rsp_l1_hit, rsp_l2_hit   hit classification (mutually exclusive)
//   cache_addr, cache_read   request side of the cache
//   cache_read_data,
//   cache_l1_hit,
//   cache_l2_hit             registered result side of the cache
//   clr_stats                synchronous clear of the statistics counters
//   cnt_l1_hit, cnt_l2_hit,
//   cnt_miss                 saturating statistics counters
// ----------------------------------------------------------------------------
module cache_req_arbiter_2way #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_l1_hit,
  output logic                  rsp_l2_hit,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_read,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  input  logic                  cache_l1_hit,
  input  logic                  cache_l2_hit,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  cnt_l1_hit,
  output logic [CNT_WIDTH-1:0]  cnt_l2_hit,
  output logic [CNT_WIDTH-1:0]  cnt_miss
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  rr_q, rr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  id_q, id_d;
  logic                  cache_read_q, cache_read_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_l1_q, rsp_l1_d;
  logic                  rsp_l2_q, rsp_l2_d;
  logic [CNT_WIDTH-1:0]  cnt_l1_hit_q, cnt_l1_hit_d;
  logic [CNT_WIDTH-1:0]  cnt_l2_hit_q, cnt_l2_hit_d;
  logic [CNT_WIDTH-1:0]  cnt_miss_q, cnt_miss_d;
  logic                  grant_vld_s;
  logic                  grant_id_s;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // Round-robin grant selection; rr_q names the preferred port on contention.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = rr_q;
    end else if (req0_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // Ready depends only on state and the valids, so it can never loop back
  // through a requester that waits for ready before raising valid.
  assign req0_ready = (state_q == ST_IDLE) && grant_vld_s && !grant_id_s;
  assign req1_ready = (state_q == ST_IDLE) && grant_vld_s &&  grant_id_s;

  // Sequencer: accept -> issue read pulse -> capture cache result -> respond.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    addr_d       = addr_q;
    id_d         = id_q;
    cache_read_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_l1_d     = rsp_l1_q;
    rsp_l2_d     = rsp_l2_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld_s) begin
          addr_d       = grant_id_s ? req1_addr : req0_addr;
          id_d         = grant_id_s;
          rr_d         = ~grant_id_s;
          // The read pulse is registered so it is high for exactly the ISSUE cycle.
          cache_read_d = 1'b1;
          state_d      = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rsp_data_d  = cache_read_data;
        rsp_l1_d    = cache_l1_hit;
        // L1 takes priority if the cache flags both levels.
        rsp_l2_d    = cache_l2_hit & ~cache_l1_hit;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Statistics: classify the captured result; a clear overrides any increment.
  always_comb begin
    cnt_l1_hit_d = cnt_l1_hit_q;
    cnt_l2_hit_d = cnt_l2_hit_q;
    cnt_miss_d   = cnt_miss_q;
    if (clr_stats) begin
      cnt_l1_hit_d = {CNT_WIDTH{1'b0}};
      cnt_l2_hit_d = {CNT_WIDTH{1'b0}};
      cnt_miss_d   = {CNT_WIDTH{1'b0}};
    end else if (state_q == ST_CAPTURE) begin
      if (cache_l1_hit) begin
        cnt_l1_hit_d = sat_inc(cnt_l1_hit_q);
      end else if (cache_l2_hit) begin
        cnt_l2_hit_d = sat_inc(cnt_l2_hit_q);
      end else begin
        cnt_miss_d = sat_inc(cnt_miss_q);
      end
    end else begin
      cnt_miss_d = cnt_miss_q;
    end
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_q         <= 1'b0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      id_q         <= 1'b0;
      cache_read_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= {DATA_WIDTH{1'b0}};
      rsp_l1_q     <= 1'b0;
      rsp_l2_q     <= 1'b0;
      cnt_l1_hit_q <= {CNT_WIDTH{1'b0}};
      cnt_l2_hit_q <= {CNT_WIDTH{1'b0}};
      cnt_miss_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      addr_q       <= addr_d;
      id_q         <= id_d;
      cache_read_q <= cache_read_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_l1_q     <= rsp_l1_d;
      rsp_l2_q     <= rsp_l2_d;
      cnt_l1_hit_q <= cnt_l1_hit_d;
      cnt_l2_hit_q <= cnt_l2_hit_d;
      cnt_miss_q   <= cnt_miss_d;
    end
  end

  assign cache_addr = addr_q;
  assign cache_read = cache_read_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_l1_hit = rsp_l1_q;
  assign rsp_l2_hit = rsp_l2_q;
  assign cnt_l1_hit = cnt_l1_hit_q;
  assign cnt_l2_hit = cnt_l2_hit_q;
  assign cnt_miss   = cnt_miss_q;

endmodule

// File: doc/cache_req_arbiter_2way.md
# cache_req_arbiter_2way

Two-port request arbiter and sequencer in front of `cache_system_2way`. It accepts read requests from two requesters over valid/ready handshakes and grants them round-robin. Each granted request is issued to the cache as a single-cycle `read` pulse. The block then captures the registered cache result and returns it on a shared, back-pressurable response channel tagged with the requester ID. It also keeps saturating L1-hit, L2-hit and miss statistics counters.

## Interface
Parameters:
- ADDR_WIDTH, 11, request/cache address width
- DATA_WIDTH, 32, read data width
- CNT_WIDTH, 16, width of each statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a request
- req0_addr  in  ADDR_WIDTH  requester 0 address
- req0_ready  out  1  requester 0 request accepted this cycle when high with req0_valid
- req1_valid / req1_addr / req1_ready  same as port 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that owns the response
- rsp_data  out  DATA_WIDTH  read data
- rsp_l1_hit  out  1  served from L1
- rsp_l2_hit  out  1  L1 miss, served from L2
- cache_addr  out  ADDR_WIDTH  to cache `addr`
- cache_read  out  1  to cache `read`
- cache_read_data  in  DATA_WIDTH  from cache `read_data`
- cache_l1_hit  in  1  from cache `l1_hit`
- cache_l2_hit  in  1  from cache `l2_hit`
- clr_stats  in  1  synchronous clear of all counters
- cnt_l1_hit / cnt_l2_hit / cnt_miss  out  CNT_WIDTH  statistics

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- Round-robin pointer `rr`: 0 means port 0 is preferred. Reset value is 0.
- Grant in IDLE:
  - Both ports valid: grant port `rr`.
  - One port valid: grant that port.
  - Neither valid: no grant.
- `reqN_ready` = (state == IDLE) && grant == N. It is combinational from the valid inputs and state, never from ready. At most one ready is high per cycle.
- Acceptance edge (valid && ready), in IDLE:
  - Latch address and ID.
  - Set `rr` to the other port.
  - Go to ISSUE.
- ISSUE:
  - `cache_read` = 1 for exactly this cycle; `cache_addr` = latched address.
  - Go to CAPTURE.
- CAPTURE:
  - `cache_read` = 0; `cache_addr` holds its value.
  - At the end-of-cycle edge, latch `cache_read_data`, `cache_l1_hit` and `cache_l2_hit` into the rsp_* registers.
  - Classify the result:
    - L1 if `l1_hit`.
    - Else L2 if `l2_hit`.
    - Else miss.
  - Increment the matching counter, then go to RESP.
- RESP:
  - `rsp_valid` = 1; payload stable until handshake.
  - On rsp_valid && rsp_ready: go to IDLE and clear `rsp_valid`.
- Counters:
  - Saturate at all-ones.
  - `clr_stats` zeroes all three counters and wins over a same-edge increment.
- `rsp_l1_hit` and `rsp_l2_hit` are never both 1. If the cache reports both, L1 wins.

## Timing
- Reset values:
  - All outputs are 0, including `reqN_ready` (state IDLE with no valid input gives 0).
  - State IDLE, `rr` = 0, counters 0.
- Reset mid-transaction: the in-flight request is dropped and no response is produced. The cache shares `rst` and is flushed simultaneously.
- Latency (accept edge E0):
  - ISSUE cycle follows E0; the cache registers its result at E1.
  - CAPTURE samples at E2.
  - `rsp_valid` is high in the cycle after E2, i.e. 3 edges after acceptance.
- Minimum request period is 4 cycles: the response handshake occurs in the first RESP cycle, and the next acceptance is in the following IDLE cycle.
- Back-pressure: while RESP waits, `cache_read` = 0 and both `reqN_ready` = 0. No request is lost or reordered.
- A requester must hold valid and addr stable until ready; the block samples addr only at the acceptance edge.

## Test plan
- **Cold miss.** After reset, req0 addr 0x123 with `rsp_ready` = 1.
  - `cache_read` is high for exactly 1 cycle with `cache_addr` = 0x123.
  - `rsp_valid` is high 3 edges after acceptance with id 0, data 0x000003F3, l1 = 0, l2 = 0.
  - `cnt_miss` = 1.
- **L1 hit.** Repeat 0x123 on port 1.
  - Response has id 1, data 0x000003F3, `rsp_l1_hit` = 1, `rsp_l2_hit` = 0.
  - `cnt_l1_hit` = 1.
- **Round-robin.** After reset, both ports continuously valid (0x010 on port 0, 0x020 on port 1) for 4 requests.
  - Grant order is 0, 1, 0, 1.
  - `rsp_id` sequence is 0, 1, 0, 1, with the matching addresses on `cache_addr`.
- **Back-pressure.** Hold `rsp_ready` = 0 for 5 cycles in RESP.
  - `rsp_valid`, `rsp_id` and `rsp_data` are stable.
  - Both readies are 0; `cache_read` is 0.
  - Response completes on the cycle `rsp_ready` rises.
- **Counter saturation and clear.** CNT_WIDTH = 2, 5 misses to distinct addresses.
  - `cnt_miss` stops at 3.
  - `clr_stats` pulsed on a miss capture edge leaves `cnt_miss` = 0.
- **Reset mid-operation.** Assert `rst` during ISSUE.
  - All outputs go to 0 immediately and no response appears.
  - The next request is then served normally as a miss.
